// File: rtl/otter_pc_pkg.sv
// Shared types and constants for the program-counter generator.
package otter_pc_pkg;

    localparam int unsigned PC_SRC_W = 3;
    localparam int unsigned PC_INC   = 4;

    // Next-PC source encoding; 6 and 7 are reserved and behave as sequential
    typedef enum logic [PC_SRC_W-1:0] {
        PC_SRC_SEQ    = 3'd0,
        PC_SRC_JALR   = 3'd1,
        PC_SRC_BRANCH = 3'd2,
        PC_SRC_JAL    = 3'd3,
        PC_SRC_TRAP   = 3'd4,
        PC_SRC_MRET   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC target select; flags sources that redirect the stream.
module pc_next_mux
    import otter_pc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]     pc,
    input  logic [PC_SRC_W-1:0] src,
    input  logic [XLEN-1:0]     jalr_in,
    input  logic [XLEN-1:0]     branch_in,
    input  logic [XLEN-1:0]     jal_in,
    input  logic [XLEN-1:0]     mtvec_in,
    input  logic [XLEN-1:0]     mepc_in,
    output logic [XLEN-1:0]     target_c,
    output logic                redirect_c
);

    // Select target; reserved encodings fall through to PC+4 (wraps naturally)
    always_comb begin
        target_c   = pc + XLEN'(PC_INC);
        redirect_c = 1'b0;
        case (pc_src_t'(src))
            PC_SRC_JALR: begin
                target_c   = {jalr_in[XLEN-1:1], 1'b0};
                redirect_c = 1'b1;
            end
            PC_SRC_BRANCH: begin
                target_c   = branch_in;
                redirect_c = 1'b1;
            end
            PC_SRC_JAL: begin
                target_c   = jal_in;
                redirect_c = 1'b1;
            end
            PC_SRC_TRAP: begin
                target_c   = {mtvec_in[XLEN-1:2], 2'b00};
                redirect_c = 1'b1;
            end
            PC_SRC_MRET: begin
                target_c   = mepc_in;
                redirect_c = 1'b1;
            end
            default: begin
                target_c   = pc + XLEN'(PC_INC);
                redirect_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot/run/pending FSM with deferred redirects.
// Optional misaligned-target rejection enabled by defining PC_MISALIGN_CHECK_EN.
module pc_gen
    import otter_pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PC_LD,
    input  logic [PC_SRC_W-1:0] PC_SOURCE,
    input  logic [XLEN-1:0]     JALR_IN,
    input  logic [XLEN-1:0]     BRANCH_IN,
    input  logic [XLEN-1:0]     JAL_IN,
    input  logic [XLEN-1:0]     MTVEC_IN,
    input  logic [XLEN-1:0]     MEPC_IN,
    output logic [XLEN-1:0]     PC_OUT,
    output logic                PC_VALID,
    output logic                REDIRECT_PENDING,
    output logic                MISALIGN,
    output logic [XLEN-1:0]     MISALIGN_ADDR
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            valid_q, valid_d;
    logic            rpend_q, rpend_d;
    logic [XLEN-1:0] target_c;
    logic            redirect_c;
    logic [XLEN-1:0] load_tgt;
    logic            do_load;
`ifdef PC_MISALIGN_CHECK_EN
    logic            mis_q, mis_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;
`endif

    pc_next_mux #(.XLEN(XLEN)) u_next_mux (
        .pc         (pc_q),
        .src        (PC_SOURCE),
        .jalr_in    (JALR_IN),
        .branch_in  (BRANCH_IN),
        .jal_in     (JAL_IN),
        .mtvec_in   (MTVEC_IN),
        .mepc_in    (MEPC_IN),
        .target_c   (target_c),
        .redirect_c (redirect_c)
    );

    // Next-state, PC load and pending-capture decisions
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        load_tgt   = target_c;
        do_load    = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
        mis_d      = 1'b0;
        mis_addr_d = mis_addr_q;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (PC_LD) begin
                    do_load = 1'b1;
                end else if (redirect_c) begin
                    pend_tgt_d = target_c;
                    state_d    = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (PC_LD) begin
                    do_load    = 1'b1;
                    load_tgt   = redirect_c ? target_c : pend_tgt_q;
                    pend_tgt_d = '0;
                    state_d    = ST_RUN;
                end else if (redirect_c) begin
                    pend_tgt_d = target_c;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Only redirect targets (current or pending) are subject to the alignment check
        if (do_load) begin
`ifdef PC_MISALIGN_CHECK_EN
            if ((state_q == ST_PENDING || redirect_c) && load_tgt[1:0] != 2'b00) begin
                mis_d      = 1'b1;
                mis_addr_d = load_tgt;
            end else begin
                pc_d = load_tgt;
            end
`else
            pc_d = load_tgt;
`endif
        end
    end

    assign valid_d = (state_d != ST_BOOT);
    assign rpend_d = (state_d == ST_PENDING);

    // State and output registers, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            pend_tgt_q <= '0;
            valid_q    <= 1'b0;
            rpend_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            valid_q    <= valid_d;
            rpend_q    <= rpend_d;
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    // Misalign pulse and last rejected address
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
        end
    end

    assign MISALIGN      = mis_q;
    assign MISALIGN_ADDR = mis_addr_q;
`else
    assign MISALIGN      = 1'b0;
    assign MISALIGN_ADDR = '0;
`endif

    assign PC_OUT           = pc_q;
    assign PC_VALID         = valid_q;
    assign REDIRECT_PENDING = rpend_q;

endmodule
